// File: rtl/xpb_digit_sequencer.sv
// Time-multiplexes one xpb lookup-table bank over the digits of a wide operand and
// accumulates the returned entries onto a seed value for the modular-square reduction.
module xpb_digit_sequencer #(
   parameter  int DIGIT_W    = 5,
   parameter  int NUM_DIGITS = 8,
   parameter  int DATA_W     = 1024,
   parameter  int LUT_LAT    = 1,
   parameter  int ACC_W      = DATA_W + 4,
   localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] operand_in,
   input  logic [DATA_W-1:0]             init_in,
   output logic                          busy,
   output logic                          done,
   output logic [ACC_W-1:0]              result,
   output logic                          lut_valid,
   output logic [SEL_W-1:0]              lut_sel,
   output logic [DIGIT_W-1:0]            lut_digit,
   input  logic [DATA_W-1:0]             lut_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

   state_t                               state_q, state_d;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   op_q, op_d;
   logic [SEL_W-1:0]                     idx_q, idx_d;
   logic [ACC_W-1:0]                     acc_q, acc_d;
   logic [ACC_W-1:0]                     result_q, result_d;
   logic                                 busy_q, busy_d;
   logic                                 done_q, done_d;
   logic                                 lut_valid_q, lut_valid_d;
   logic [DIGIT_W-1:0]                   lut_digit_q, lut_digit_d;
   logic                                 ret_valid;
   logic                                 drain_last;
   logic                                 accept;

   // Return tracking: ret_valid marks the cycle in which lut_data belongs to an issued lookup.
   if (LUT_LAT == 0) begin : g_no_pipe
      assign ret_valid  = lut_valid_q;
      assign drain_last = 1'b1;
   end else begin : g_pipe
      logic [LUT_LAT-1:0] vpipe_q, vpipe_d;

      always_comb begin
         vpipe_d    = vpipe_q << 1;
         vpipe_d[0] = lut_valid_q;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) vpipe_q <= '0;
         else       vpipe_q <= vpipe_d;
      end

      assign ret_valid  = vpipe_q[LUT_LAT-1];
      // In DRAIN nothing new enters, so an empty next pipe means this is the last return.
      assign drain_last = (vpipe_d == '0);
   end

   always_comb begin
      // NOTE: every _d gets a default here so no path through the case can infer a latch.
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      result_d    = result_q;
      lut_valid_d = 1'b0;
      lut_digit_d = '0;
      accept      = 1'b0;
      acc_d       = ret_valid ? (acc_q + ACC_W'(lut_data)) : acc_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) accept  = 1'b1;
            else       state_d = IDLE;
         end
         ISSUE: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = (LUT_LAT > 0) ? DRAIN : DONE;
            end else begin
               idx_d       = idx_q + 1'b1;
               lut_valid_d = 1'b1;
               lut_digit_d = op_q[idx_d];
            end
         end
         DRAIN: begin
            if (drain_last) state_d = DONE;
         end
      endcase

      // The pipe is always empty in IDLE/DONE, so seeding acc cannot drop a return.
      if (accept) begin
         state_d     = ISSUE;
         op_d        = operand_in;
         acc_d       = ACC_W'(init_in);
         idx_d       = '0;
         lut_valid_d = 1'b1;
         lut_digit_d = operand_in[DIGIT_W-1:0];
      end

      done_d = (state_d == DONE);
      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      if (done_d) result_d = acc_d;
   end

   // NOTE: non-blocking assignments only in sequential logic, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         lut_valid_q <= 1'b0;
         lut_digit_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         lut_valid_q <= lut_valid_d;
         lut_digit_q <= lut_digit_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign lut_valid = lut_valid_q;
   assign lut_sel   = idx_q;
   assign lut_digit = lut_digit_q;

endmodule

// File: tb/tb_xpb_digit_sequencer.sv
// Directed bench for xpb_digit_sequencer: three latency variants, a table model per variant,
// and a scoreboard of expected results/done cycles checked whenever the LUT_LAT=1 unit pulses done.
module tb_xpb_digit_sequencer;

   localparam int DIGIT_W    = 5;
   localparam int NUM_DIGITS = 8;
   localparam int DATA_W     = 1024;
   localparam int ACC_W      = DATA_W + 4;
   localparam int OP_W       = NUM_DIGITS * DIGIT_W;
   localparam int CW         = 520;
   localparam logic [DATA_W-1:0] JUNK = {(DATA_W/16){16'hDEAD}};

   typedef struct {
      logic [ACC_W-1:0] res;
      int               cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [OP_W-1:0]   operand_in = '0;
   logic [DATA_W-1:0] init_in = '0;
   logic              mode = 1'b0;

   logic busy1, done1, lut_valid1, busy0, done0, lut_valid0, busy3, done3, lut_valid3;
   logic [ACC_W-1:0] result1, result0, result3;
   logic [2:0] lut_sel1, lut_sel0, lut_sel3;
   logic [DIGIT_W-1:0] lut_digit1, lut_digit0, lut_digit3;
   logic [DATA_W-1:0] lut_data1, lut_data0, lut_data3;

   exp_t sb[$];
   int   cyc = 0;
   int   t0 = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] lut_fn(input logic m, input logic [2:0] sel,
                                                input logic [DIGIT_W-1:0] dig);
      if (m) return '1;
      return DATA_W'(dig) << (8 * sel);
   endfunction

   function automatic logic [ACC_W-1:0] exp_sum(input logic m, input logic [DATA_W-1:0] init,
                                                input logic [OP_W-1:0] op);
      logic [ACC_W-1:0] s;
      s = ACC_W'(init);
      for (int i = 0; i < NUM_DIGITS; i++)
         s = s + ACC_W'(lut_fn(m, 3'(i), op[i*DIGIT_W +: DIGIT_W]));
      return s;
   endfunction

   // Table models: data appears exactly LUT_LAT cycles after the lookup, junk otherwise.
   logic v1 = 1'b0;
   logic [2:0] s1 = '0;
   logic [DIGIT_W-1:0] g1 = '0;
   logic [2:0] v3 = '0;
   logic [2:0][2:0] s3 = '0;
   logic [2:0][DIGIT_W-1:0] g3 = '0;

   always @(posedge clk) begin
      v1 <= lut_valid1;
      s1 <= lut_sel1;
      g1 <= lut_digit1;
      v3 <= {v3[1:0], lut_valid3};
      s3 <= {s3[1:0], lut_sel3};
      g3 <= {g3[1:0], lut_digit3};
   end

   assign lut_data1 = v1 ? lut_fn(mode, s1, g1) : JUNK;
   assign lut_data0 = lut_valid0 ? lut_fn(mode, lut_sel0, lut_digit0) : JUNK;
   assign lut_data3 = v3[2] ? lut_fn(mode, s3[2], g3[2]) : JUNK;

   xpb_digit_sequencer #(.LUT_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .operand_in(operand_in), .init_in(init_in),
      .busy(busy1), .done(done1), .result(result1), .lut_valid(lut_valid1),
      .lut_sel(lut_sel1), .lut_digit(lut_digit1), .lut_data(lut_data1));

   xpb_digit_sequencer #(.LUT_LAT(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .operand_in(operand_in), .init_in(init_in),
      .busy(busy0), .done(done0), .result(result0), .lut_valid(lut_valid0),
      .lut_sel(lut_sel0), .lut_digit(lut_digit0), .lut_data(lut_data0));

   xpb_digit_sequencer #(.LUT_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .operand_in(operand_in), .init_in(init_in),
      .busy(busy3), .done(done3), .result(result3), .lut_valid(lut_valid3),
      .lut_sel(lut_sel3), .lut_digit(lut_digit3), .lut_data(lut_data3));

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_res(input string tag, input logic [ACC_W-1:0] obs,
                            input logic [ACC_W-1:0] exp);
      check({tag, "_lo"}, obs[CW-1:0], exp[CW-1:0]);
      check({tag, "_hi"}, CW'(obs[ACC_W-1:CW]), CW'(exp[ACC_W-1:CW]));
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Drive a start at the current negedge (cycle 0) and schedule its expected done at cycle 10.
   task automatic launch(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] init,
                         input logic [ACC_W-1:0] exp_res);
      exp_t e;
      operand_in = op;
      init_in    = init;
      start      = 1'b1;
      t0         = cyc;
      e.res      = exp_res;
      e.cyc      = cyc + 10;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (done1) begin
         if (sb.size() == 0) begin
            check("spurious_done", CW'(done1), CW'(0));
         end else begin
            e = sb.pop_front();
            check_res("result", result1, e.res);
            check("done_cycle", CW'(cyc), CW'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OP_W-1:0]  op_ones, op_a, op_b, op_c;
      logic [ACC_W-1:0] exp1, exp_big, res0, res3;
      int n_done0, n_done3, cyc0, cyc3, n_iss, n_nz;

      op_ones = {NUM_DIGITS{5'h1F}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         op_a[i*DIGIT_W +: DIGIT_W] = 5'(i + 1);
         op_b[i*DIGIT_W +: DIGIT_W] = 5'(31 - i);
      end
      op_c    = {8'($urandom), 32'($urandom)};
      exp1    = ACC_W'(64'h1F1F1F1F1F1F1F1F);
      exp_big = ((ACC_W'(1) << DATA_W) - ACC_W'(1)) * ACC_W'(9);

      // Reset state
      tick(); tick();
      check("rst_busy", CW'(busy1), CW'(0));
      check("rst_done", CW'(done1), CW'(0));
      check("rst_lut_valid", CW'(lut_valid1), CW'(0));
      check("rst_lut_sel", CW'(lut_sel1), CW'(0));
      check("rst_lut_digit", CW'(lut_digit1), CW'(0));
      check_res("rst_result", result1, '0);
      reset = 1'b0;
      tick();

      // All digits 1F, all three latencies side by side
      mode = 1'b0;
      launch(op_ones, '0, exp1);
      n_done0 = 0; n_done3 = 0; cyc0 = -1; cyc3 = -1; res0 = '0; res3 = '0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         start = 1'b0;
         check("s1_lut_valid", CW'(lut_valid1), CW'(k <= 8));
         if (k <= 8) begin
            check("s1_lut_sel", CW'(lut_sel1), CW'(k - 1));
            check("s1_lut_digit", CW'(lut_digit1), CW'(5'h1F));
         end
         check("s1_busy", CW'(busy1), CW'(k <= 9));
         if (done0) begin n_done0++; cyc0 = k; res0 = result0; end
         if (done3) begin n_done3++; cyc3 = k; res3 = result3; end
      end
      check("lat0_done_count", CW'(n_done0), CW'(1));
      check("lat0_done_cycle", CW'(cyc0), CW'(9));
      check_res("lat0_result", res0, exp1);
      check("lat3_done_count", CW'(n_done3), CW'(1));
      check("lat3_done_cycle", CW'(cyc3), CW'(12));
      check_res("lat3_result", res3, exp1);
      check("s1_sb_empty", CW'(sb.size()), CW'(0));

      // Zero operand: every digit still issued, result is the seed
      launch('0, DATA_W'(12'h100), ACC_W'(12'h100));
      n_iss = 0; n_nz = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         start = 1'b0;
         if (lut_valid1) begin
            n_iss++;
            if (lut_digit1 != '0) n_nz++;
         end
      end
      check("s2_issue_count", CW'(n_iss), CW'(8));
      check("s2_nonzero_digits", CW'(n_nz), CW'(0));
      check("s2_sb_empty", CW'(sb.size()), CW'(0));

      // All-ones table and seed: 9*(2^1024-1) must fit without wrap
      mode = 1'b1;
      launch(op_a, '1, exp_big);
      for (int k = 1; k <= 12; k++) begin
         tick();
         start = 1'b0;
      end
      mode = 1'b0;
      check("s3_sb_empty", CW'(sb.size()), CW'(0));

      // start held high: back-to-back operations, operand re-captured in each DONE cycle
      launch(op_a, '0, exp_sum(1'b0, '0, op_a));
      for (int k = 1; k <= 31; k++) begin
         tick();
         if (k == 10) begin
            operand_in = op_b;
            init_in    = DATA_W'(7);
            sb.push_back('{res: exp_sum(1'b0, DATA_W'(7), op_b), cyc: t0 + 20});
         end
         if (k == 15) operand_in = ~op_b;
         if (k == 20) begin
            operand_in = op_c;
            init_in    = '0;
            sb.push_back('{res: exp_sum(1'b0, '0, op_c), cyc: t0 + 30});
         end
         if (k == 30) start = 1'b0;
      end
      check("s4_busy_after", CW'(busy1), CW'(0));
      check("s4_sb_empty", CW'(sb.size()), CW'(0));

      // A second start mid-operation is ignored
      launch(op_a, DATA_W'(3), exp_sum(1'b0, DATA_W'(3), op_a));
      for (int k = 1; k <= 14; k++) begin
         tick();
         start = (k == 4);
         if (k == 4) begin
            operand_in = op_b;
            init_in    = DATA_W'(123);
         end
      end
      check("s5_sb_empty", CW'(sb.size()), CW'(0));

      // Reset mid-operation: immediate clear, no done, then a clean operation
      launch(op_b, '0, exp_sum(1'b0, '0, op_b));
      for (int k = 1; k <= 5; k++) begin
         tick();
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      sb.delete();
      check("s6_busy", CW'(busy1), CW'(0));
      check("s6_lut_valid", CW'(lut_valid1), CW'(0));
      check("s6_done", CW'(done1), CW'(0));
      check_res("s6_result", result1, '0);
      tick(); tick();
      reset = 1'b0;
      repeat (15) tick();
      launch(op_c, DATA_W'(9), exp_sum(1'b0, DATA_W'(9), op_c));
      for (int k = 1; k <= 12; k++) begin
         tick();
         start = 1'b0;
      end
      check("s6_sb_empty", CW'(sb.size()), CW'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
